// File: rtl/header_parser.sv
// -----------------------------------------------------------------------------
// header_parser
//
// Walks a captured packet header one protocol layer per clock:
//   ETH -> (VLAN) -> (IPV4) -> (TCP | UDP)
// and reports, for each known header ID, whether it is present and at which
// byte offset it starts. Header IDs: 0 Ethernet, 1 IPv4, 2 TCP, 3 UDP, 4 VLAN.
// All other IDs always read offset 0 / valid 0.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            asynchronous reset, active low
//   start_i        new header available (only looked at while idle)
//   pkt_hdr_i      raw header, byte 0 (first on the wire) in bits [7:0]
//   ready_o        parse finished; every output below is valid while high
//   pkt_hdr_o      copy of pkt_hdr_i taken when start_i was accepted
//   parsed_hdrs_o  32-bit byte offset per header ID, ID i in bits [i*32 +: 32]
//   hdr_valid_o    bit i set = header ID i present
//   err_o          malformed (IHL < 5) or truncated header seen
// -----------------------------------------------------------------------------
module header_parser #(
    parameter int HDR_MAX_LEN = 64,
    parameter int NUM_HEADERS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [HDR_MAX_LEN*8-1:0]  pkt_hdr_i,
    output logic                      ready_o,
    output logic [HDR_MAX_LEN*8-1:0]  pkt_hdr_o,
    output logic [NUM_HEADERS*32-1:0] parsed_hdrs_o,
    output logic [NUM_HEADERS-1:0]    hdr_valid_o,
    output logic                      err_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ETH  = 3'd1;
    localparam logic [2:0] ST_VLAN = 3'd2;
    localparam logic [2:0] ST_IPV4 = 3'd3;
    localparam logic [2:0] ST_L4   = 3'd4;

    localparam int ID_ETH  = 0;
    localparam int ID_IPV4 = 1;
    localparam int ID_TCP  = 2;
    localparam int ID_UDP  = 3;
    localparam int ID_VLAN = 4;

    localparam int AW = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;

    logic [2:0]  state_reg;
    logic [31:0] cur_off_reg;          // offset of the header the next state parses
    logic        l4_udp_reg;           // L4 state parses UDP (1) or TCP (0)
    logic        ready_reg;
    logic        err_reg;
    logic [NUM_HEADERS-1:0] valid_reg;
    logic [31:0] off_reg [NUM_HEADERS];
    logic [7:0]  hdr_mem_reg [HDR_MAX_LEN];

    // Byte fetch from the captured header; anything past the end reads as 0.
    // Every state checks truncation before trusting what it reads.
    function automatic logic [7:0] hdr_byte(input logic [31:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx < 32'(HDR_MAX_LEN)) begin
            b = hdr_mem_reg[idx[AW-1:0]];
        end
        return b;
    endfunction

    function automatic logic [3:0] hdr_low_nibble(input logic [31:0] idx);
        logic [3:0] n;
        n = 4'h0;
        if (idx < 32'(HDR_MAX_LEN)) begin
            n = hdr_mem_reg[idx[AW-1:0]][3:0];
        end
        return n;
    endfunction

    // off + len <= HDR_MAX_LEN, evaluated in 33 bits so a huge offset cannot wrap.
    function automatic logic fits(input logic [31:0] off, input logic [31:0] len);
        return ({1'b0, off} + {1'b0, len}) <= 33'(HDR_MAX_LEN);
    endfunction

    logic [15:0] eth_type;
    logic [15:0] vlan_type;
    logic [3:0]  ip_ihl;
    logic [31:0] ip_len;
    logic [7:0]  ip_proto;
    logic [31:0] l4_min_len;

    always_comb begin
        eth_type   = {hdr_byte(32'd12), hdr_byte(32'd13)};
        vlan_type  = {hdr_byte(32'd16), hdr_byte(32'd17)};
        ip_ihl     = hdr_low_nibble(cur_off_reg);
        ip_len     = {26'd0, ip_ihl, 2'b00};
        ip_proto   = hdr_byte(cur_off_reg + 32'd9);
        l4_min_len = l4_udp_reg ? 32'd8 : 32'd20;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            cur_off_reg <= '0;
            l4_udp_reg  <= 1'b0;
            ready_reg   <= 1'b0;
            err_reg     <= 1'b0;
            valid_reg   <= '0;
            for (int i = 0; i < NUM_HEADERS; i++) begin
                off_reg[i] <= '0;
            end
            for (int i = 0; i < HDR_MAX_LEN; i++) begin
                hdr_mem_reg[i] <= 8'h00;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Outputs hold their last result here until a new start.
                    if (start_i) begin
                        for (int i = 0; i < HDR_MAX_LEN; i++) begin
                            hdr_mem_reg[i] <= pkt_hdr_i[i*8 +: 8];
                        end
                        for (int i = 0; i < NUM_HEADERS; i++) begin
                            off_reg[i] <= '0;
                        end
                        valid_reg   <= '0;
                        err_reg     <= 1'b0;
                        ready_reg   <= 1'b0;
                        cur_off_reg <= '0;
                        state_reg   <= ST_ETH;
                    end
                end

                ST_ETH: begin
                    if (!fits(32'd0, 32'd14)) begin
                        err_reg   <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        valid_reg[ID_ETH] <= 1'b1;
                        off_reg[ID_ETH]   <= 32'd0;
                        if (eth_type == 16'h8100) begin
                            cur_off_reg <= 32'd14;
                            state_reg   <= ST_VLAN;
                        end else if (eth_type == 16'h0800) begin
                            cur_off_reg <= 32'd14;
                            state_reg   <= ST_IPV4;
                        end else begin
                            ready_reg <= 1'b1;
                            state_reg <= ST_IDLE;
                        end
                    end
                end

                ST_VLAN: begin
                    if (!fits(32'd14, 32'd4)) begin
                        err_reg   <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        valid_reg[ID_VLAN] <= 1'b1;
                        off_reg[ID_VLAN]   <= 32'd14;
                        if (vlan_type == 16'h0800) begin
                            cur_off_reg <= 32'd18;
                            state_reg   <= ST_IPV4;
                        end else begin
                            ready_reg <= 1'b1;
                            state_reg <= ST_IDLE;
                        end
                    end
                end

                ST_IPV4: begin
                    if (cur_off_reg >= 32'(HDR_MAX_LEN)) begin
                        // Not even the version/IHL byte is inside the buffer.
                        err_reg   <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else if (ip_ihl < 4'd5) begin
                        // Malformed but present: the header is still reported.
                        valid_reg[ID_IPV4] <= 1'b1;
                        off_reg[ID_IPV4]   <= cur_off_reg;
                        err_reg            <= 1'b1;
                        ready_reg          <= 1'b1;
                        state_reg          <= ST_IDLE;
                    end else if (!fits(cur_off_reg, ip_len)) begin
                        err_reg   <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        valid_reg[ID_IPV4] <= 1'b1;
                        off_reg[ID_IPV4]   <= cur_off_reg;
                        if (ip_proto == 8'd6 || ip_proto == 8'd17) begin
                            l4_udp_reg  <= (ip_proto == 8'd17);
                            cur_off_reg <= cur_off_reg + ip_len;
                            state_reg   <= ST_L4;
                        end else begin
                            ready_reg <= 1'b1;
                            state_reg <= ST_IDLE;
                        end
                    end
                end

                ST_L4: begin
                    if (!fits(cur_off_reg, l4_min_len)) begin
                        err_reg <= 1'b1;
                    end else if (l4_udp_reg) begin
                        valid_reg[ID_UDP] <= 1'b1;
                        off_reg[ID_UDP]   <= cur_off_reg;
                    end else begin
                        valid_reg[ID_TCP] <= 1'b1;
                        off_reg[ID_TCP]   <= cur_off_reg;
                    end
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = ready_reg;
    assign err_o       = err_reg;
    assign hdr_valid_o = valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < HDR_MAX_LEN; gi++) begin : g_pkt_out
            assign pkt_hdr_o[gi*8 +: 8] = hdr_mem_reg[gi];
        end
        for (gi = 0; gi < NUM_HEADERS; gi++) begin : g_off_out
            assign parsed_hdrs_o[gi*32 +: 32] = off_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_header_parser.sv
module tb_header_parser;

    localparam int MAXL = 64;
    localparam int NH   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [MAXL*8-1:0] pkt_hdr_i = '0;
    logic              ready_o;
    logic [MAXL*8-1:0] pkt_hdr_o;
    logic [NH*32-1:0]  parsed_hdrs_o;
    logic [NH-1:0]     hdr_valid_o;
    logic              err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    header_parser #(
        .HDR_MAX_LEN(MAXL),
        .NUM_HEADERS(NH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .pkt_hdr_i    (pkt_hdr_i),
        .ready_o      (ready_o),
        .pkt_hdr_o    (pkt_hdr_o),
        .parsed_hdrs_o(parsed_hdrs_o),
        .hdr_valid_o  (hdr_valid_o),
        .err_o        (err_o)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bget(input logic [511:0] p, input int i);
        if (i >= 0 && i < MAXL) return p[i*8 +: 8];
        return 8'h00;
    endfunction

    // Build a header: random filler with the fields the parser looks at forced.
    function automatic logic [511:0] build(input logic [15:0] et, input logic [15:0] inner,
                                           input logic [3:0] ihl, input logic [7:0] proto);
        logic [511:0] p;
        int ip;
        for (int i = 0; i < MAXL; i++) p[i*8 +: 8] = 8'($urandom);
        p[12*8 +: 8] = et[15:8];
        p[13*8 +: 8] = et[7:0];
        ip = 14;
        if (et == 16'h8100) begin
            p[16*8 +: 8] = inner[15:8];
            p[17*8 +: 8] = inner[7:0];
            ip = 18;
        end
        p[ip*8 +: 8]     = {4'h4, ihl};
        p[(ip+9)*8 +: 8] = proto;
        return p;
    endfunction

    // Reference: walk the layers with plain integer arithmetic.
    function automatic void model(input logic [511:0] p, output logic [15:0] v,
                                  output logic [511:0] offs, output logic err, output int n);
        logic [15:0] et;
        logic [15:0] inner;
        int ip, ihl, proto, l4, l4len, l4id;
        v = '0; offs = '0; err = 1'b0; n = 1; ip = -1; l4id = -1; l4len = 0;
        et = {bget(p, 12), bget(p, 13)};
        v[0] = 1'b1;
        if (et == 16'h8100) begin
            n++;
            v[4] = 1'b1;
            offs[4*32 +: 32] = 32'd14;
            inner = {bget(p, 16), bget(p, 17)};
            if (inner == 16'h0800) ip = 18;
        end else if (et == 16'h0800) begin
            ip = 14;
        end
        if (ip >= 0) begin
            n++;
            ihl = int'(bget(p, ip) & 8'h0f);
            if (ihl < 5) begin
                v[1] = 1'b1;
                offs[32 +: 32] = 32'(ip);
                err = 1'b1;
            end else if (ip + ihl * 4 > MAXL) begin
                err = 1'b1;
            end else begin
                v[1] = 1'b1;
                offs[32 +: 32] = 32'(ip);
                proto = int'(bget(p, ip + 9));
                if (proto == 6) begin l4id = 2; l4len = 20; end
                else if (proto == 17) begin l4id = 3; l4len = 8; end
                if (l4id > 0) begin
                    n++;
                    l4 = ip + ihl * 4;
                    if (l4 + l4len > MAXL) err = 1'b1;
                    else begin
                        v[l4id] = 1'b1;
                        offs[l4id*32 +: 32] = 32'(l4);
                    end
                end
            end
        end
    endfunction

    // Accept one packet and check the full result plus the ready latency.
    task automatic run_pkt(input string tag, input logic [511:0] p, input logic [15:0] ev,
                           input logic ee, input logic [511:0] eo, input int en);
        int cnt;
        @(negedge clk);
        pkt_hdr_i = p;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk({tag, ".ready_clr"}, 512'(ready_o), 512'd0);
        cnt = 0;
        while (!ready_o && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, ".ready_seen"}, 512'(ready_o), 512'd1);
        chk({tag, ".latency"}, 512'(cnt), 512'(en));
        chk({tag, ".valid"}, 512'(hdr_valid_o), 512'(ev));
        chk({tag, ".err"}, 512'(err_o), 512'(ee));
        chk({tag, ".offsets"}, parsed_hdrs_o, eo);
        chk({tag, ".pkt_copy"}, pkt_hdr_o, p);
        $display("%s: valid=%h err=%b states=%0d ready_after=%0d", tag, hdr_valid_o, err_o, en, cnt);
    endtask

    typedef struct {
        logic [15:0] et;
        logic [15:0] inner;
        logic [3:0]  ihl;
        logic [7:0]  proto;
        logic [15:0] ev;
        logic        ee;
        int          ip_off;
        int          l4_off;
        int          n;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [511:0] p1, p2, p, eo;
        logic [15:0]  ev;
        logic         ee;
        int           en, spur;
        logic [15:0]  et, inner;

        tbl[0] = '{16'h0800, 16'h0000, 4'd5,  8'd6,  16'h0007, 1'b0, 14, 34, 3};
        tbl[1] = '{16'h8100, 16'h0800, 4'd6,  8'd17, 16'h001B, 1'b0, 18, 42, 4};
        tbl[2] = '{16'h0806, 16'h0000, 4'd5,  8'd6,  16'h0001, 1'b0, 0,  0,  1};
        tbl[3] = '{16'h0800, 16'h0000, 4'd3,  8'd6,  16'h0003, 1'b1, 14, 0,  2};
        tbl[4] = '{16'h0800, 16'h0000, 4'd15, 8'd6,  16'h0001, 1'b1, 0,  0,  2};
        tbl[5] = '{16'h8100, 16'h86DD, 4'd5,  8'd6,  16'h0011, 1'b0, 0,  0,  2};
        tbl[6] = '{16'h8100, 16'h0800, 4'd5,  8'd1,  16'h0013, 1'b0, 18, 0,  3};
        tbl[7] = '{16'h8100, 16'h0800, 4'd11, 8'd6,  16'h0013, 1'b1, 18, 0,  4};
        tbl[8] = '{16'h0800, 16'h0000, 4'd10, 8'd17, 16'h000B, 1'b0, 14, 54, 3};
        tbl[9] = '{16'h0800, 16'h0000, 4'd12, 8'd17, 16'h0003, 1'b1, 14, 0,  3};

        // Reset applied before any clock edge must already clear everything.
        #2;
        rst = 1'b0;
        #1;
        chk("reset.ready", 512'(ready_o), 512'd0);
        chk("reset.err", 512'(err_o), 512'd0);
        chk("reset.valid", 512'(hdr_valid_o), 512'd0);
        chk("reset.offsets", parsed_hdrs_o, 512'd0);
        chk("reset.pkt", pkt_hdr_o, 512'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        spur = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ready_o) spur++;
        end
        chk("reset.no_ready_idle", 512'(spur), 512'd0);

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            p  = build(tbl[i].et, tbl[i].inner, tbl[i].ihl, tbl[i].proto);
            eo = '0;
            if (tbl[i].ev[1]) eo[1*32 +: 32] = 32'(tbl[i].ip_off);
            if (tbl[i].ev[2]) eo[2*32 +: 32] = 32'(tbl[i].l4_off);
            if (tbl[i].ev[3]) eo[3*32 +: 32] = 32'(tbl[i].l4_off);
            if (tbl[i].ev[4]) eo[4*32 +: 32] = 32'd14;
            run_pkt($sformatf("vec%0d", i), p, tbl[i].ev, tbl[i].ee, eo, tbl[i].n);
        end

        // Outputs hold while idle after completion.
        repeat (3) @(posedge clk);
        #1;
        chk("hold.ready", 512'(ready_o), 512'd1);
        chk("hold.valid", 512'(hdr_valid_o), 512'h0003);
        chk("hold.err", 512'(err_o), 512'd1);

        // start_i pulsed while parsing IPv4 must be ignored.
        p1 = build(16'h0800, 16'h0000, 4'd5, 8'd6);
        p2 = build(16'h8100, 16'h0800, 4'd6, 8'd17);
        @(negedge clk);
        pkt_hdr_i = p1;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        pkt_hdr_i = p2;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("ignore.pkt", pkt_hdr_o, p1);
        chk("ignore.ready_low", 512'(ready_o), 512'd0);
        @(posedge clk);
        #1;
        eo = '0;
        eo[1*32 +: 32] = 32'd14;
        eo[2*32 +: 32] = 32'd34;
        chk("ignore.ready", 512'(ready_o), 512'd1);
        chk("ignore.valid", 512'(hdr_valid_o), 512'h0007);
        chk("ignore.offsets", parsed_hdrs_o, eo);
        $display("ignore: valid=%h err=%b", hdr_valid_o, err_o);

        // Back-to-back: next packet accepted while ready_o is still high.
        model(p2, ev, eo, ee, en);
        run_pkt("b2b", p2, ev, ee, eo, en);

        // Asynchronous reset between edges in the middle of a parse.
        @(negedge clk);
        pkt_hdr_i = p2;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midreset.ready", 512'(ready_o), 512'd0);
        chk("midreset.err", 512'(err_o), 512'd0);
        chk("midreset.valid", 512'(hdr_valid_o), 512'd0);
        chk("midreset.offsets", parsed_hdrs_o, 512'd0);
        chk("midreset.pkt", pkt_hdr_o, 512'd0);
        $display("midreset: ready=%b valid=%h", ready_o, hdr_valid_o);
        @(negedge clk);
        rst = 1'b1;
        spur = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ready_o) spur++;
        end
        chk("midreset.no_ready", 512'(spur), 512'd0);

        // Randomized packets against the reference model.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       et = 16'h0800;
                1:       et = 16'h8100;
                2:       et = 16'h0806;
                default: et = 16'($urandom);
            endcase
            inner = ($urandom_range(0, 2) != 0) ? 16'h0800 : 16'($urandom);
            case ($urandom_range(0, 2))
                0:       p = build(et, inner, 4'($urandom), 8'd6);
                1:       p = build(et, inner, 4'($urandom), 8'd17);
                default: p = build(et, inner, 4'($urandom), 8'($urandom));
            endcase
            model(p, ev, eo, ee, en);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_pkt($sformatf("rand%0d", k), p, ev, ee, eo, en);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
